// File: rtl/vga_fetch_pkg.sv
// Shared constants and types for the VGA pixel-fetch stage.
// Optional test-pattern build is selected with VGA_FETCH_TESTPAT_EN (see vga_pixel_fetch).
package vga_fetch_pkg;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;

  localparam int DEF_IMG_W  = 256;
  localparam int DEF_IMG_H  = 256;
  localparam int DEF_H_OFF  = (H_ACTIVE - DEF_IMG_W) / 2;
  localparam int DEF_V_OFF  = (V_ACTIVE - DEF_IMG_H) / 2;
  localparam int DEF_RD_LAT = 2;
  localparam logic [7:0] DEF_BORDER_GRAY = 8'h20;

  typedef enum logic [1:0] {
    PIX_BLACK  = 2'd0,
    PIX_BORDER = 2'd1,
    PIX_IMAGE  = 2'd2
  } pix_class_t;

  // rel is coord-offset with 10-bit wrap, so coordinates left of/above the
  // window wrap to large values and fall outside the span.
  function automatic logic rel_in_span(input logic [9:0] rel, input int size);
    return ({1'b0, rel} < 11'(size));
  endfunction

endpackage

// File: rtl/vga_pixel_fetch_sig_delay.sv
// Fixed-depth shift register with a per-bit reset value; carries the
// classification and DAC strobes alongside the framebuffer read latency.
module sig_delay
  import vga_fetch_pkg::*;
#(
  parameter int             W       = 1,
  parameter int             DEPTH   = 1,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] stage [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= RST_VAL;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[DEPTH-1];

endmodule

// File: rtl/vga_pixel_fetch.sv
// Maps the 640x480 raster onto a framebuffer window, issues reads and drives grey RGB.
// Define VGA_FETCH_TESTPAT_EN to add the test_en port and the x^y test pattern.
module vga_pixel_fetch
  import vga_fetch_pkg::*;
#(
  parameter int         IMG_W       = DEF_IMG_W,
  parameter int         IMG_H       = DEF_IMG_H,
  parameter int         H_OFF       = DEF_H_OFF,
  parameter int         V_OFF       = DEF_V_OFF,
  parameter int         RD_LAT      = DEF_RD_LAT,
  parameter logic [7:0] BORDER_GRAY = DEF_BORDER_GRAY
) (
  input  logic        clk,
  input  logic        reset,
`ifdef VGA_FETCH_TESTPAT_EN
  input  logic        test_en,
`endif
  input  logic [9:0]  in_x,
  input  logic [9:0]  in_y,
  input  logic        in_video_on,
  input  logic        in_hsync,
  input  logic        in_vsync,
  input  logic        in_blank,
  input  logic        in_sync,
  output logic [15:0] pix_addr,
  output logic        pix_rd_en,
  input  logic [7:0]  pix_data,
  output logic        hsync,
  output logic        vsync,
  output logic        blank,
  output logic        sync,
  output logic [7:0]  rgb_r,
  output logic [7:0]  rgb_g,
  output logic [7:0]  rgb_b,
  output logic        frame_start
);

  localparam int L      = RD_LAT + 1;
  localparam int BASE_W = 7;
  // base bus: {frame_start, class[1:0], hsync, vsync, blank, sync}
  localparam logic [BASE_W-1:0] BASE_RST = 7'b000_1100;
`ifdef VGA_FETCH_TESTPAT_EN
  localparam int DW = BASE_W + 9;
  localparam logic [DW-1:0] DLY_RST = {9'd0, BASE_RST};
`else
  localparam int DW = BASE_W;
  localparam logic [DW-1:0] DLY_RST = BASE_RST;
`endif

  logic [9:0]  x_rel;
  logic [9:0]  y_rel;
  logic        in_win;
  logic        fs_in;
  logic        rd_ok;
  pix_class_t  cls_in;
  logic [DW-1:0] dly_in;
  logic [DW-1:0] dly_out;
  pix_class_t  cls_d;
  logic [7:0]  img_gray;
  logic [7:0]  gray_nxt;

  assign x_rel  = in_x - 10'(H_OFF);
  assign y_rel  = in_y - 10'(V_OFF);
  assign in_win = in_video_on & rel_in_span(x_rel, IMG_W) & rel_in_span(y_rel, IMG_H);
  assign fs_in  = in_video_on & (in_x == 10'd0) & (in_y == 10'd0);

  always_comb begin
    cls_in = PIX_BLACK;
    if (in_win)           cls_in = PIX_IMAGE;
    else if (in_video_on) cls_in = PIX_BORDER;
  end

`ifdef VGA_FETCH_TESTPAT_EN
  assign rd_ok  = ~test_en;
  assign dly_in = {test_en, x_rel[7:0] ^ y_rel[7:0],
                   fs_in, cls_in, in_hsync, in_vsync, in_blank, in_sync};
`else
  assign rd_ok  = 1'b1;
  assign dly_in = {fs_in, cls_in, in_hsync, in_vsync, in_blank, in_sync};
`endif

  // Address holds while outside the window so the read port stays quiet.
  always_ff @(posedge clk) begin
    if (reset) begin
      pix_addr  <= 16'h0000;
      pix_rd_en <= 1'b0;
    end else begin
      pix_rd_en <= in_win & rd_ok;
      if (in_win) pix_addr <= {y_rel[7:0], x_rel[7:0]};
    end
  end

  sig_delay #(
    .W      (DW),
    .DEPTH  (L),
    .RST_VAL(DLY_RST)
  ) u_dly (
    .clk  (clk),
    .reset(reset),
    .d    (dly_in),
    .q    (dly_out)
  );

  assign cls_d = pix_class_t'(dly_out[5:4]);

`ifdef VGA_FETCH_TESTPAT_EN
  assign img_gray = dly_out[DW-1] ? dly_out[DW-2:BASE_W] : pix_data;
`else
  assign img_gray = pix_data;
`endif

  always_comb begin
    gray_nxt = 8'h00;
    case (cls_d)
      PIX_IMAGE:  gray_nxt = img_gray;
      PIX_BORDER: gray_nxt = BORDER_GRAY;
      default:    gray_nxt = 8'h00;
    endcase
  end

  // Output register sits on the edge where pix_data for this pixel is valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      blank       <= 1'b0;
      sync        <= 1'b0;
      rgb_r       <= 8'h00;
      rgb_g       <= 8'h00;
      rgb_b       <= 8'h00;
      frame_start <= 1'b0;
    end else begin
      hsync       <= dly_out[3];
      vsync       <= dly_out[2];
      blank       <= dly_out[1];
      sync        <= dly_out[0];
      rgb_r       <= gray_nxt;
      rgb_g       <= gray_nxt;
      rgb_b       <= gray_nxt;
      frame_start <= dly_out[6];
    end
  end

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// Directed bench for vga_pixel_fetch with a scoreboard of expected outputs.
module tb_vga_pixel_fetch;

  localparam int L = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [9:0]  in_x, in_y;
  logic        in_video_on, in_hsync, in_vsync, in_blank, in_sync;
  logic [15:0] pix_addr;
  logic        pix_rd_en;
  logic [7:0]  pix_data;
  logic        hsync, vsync, blank, sync;
  logic [7:0]  rgb_r, rgb_g, rgb_b;
  logic        frame_start;
`ifdef VGA_FETCH_TESTPAT_EN
  logic        test_en;
`endif

  vga_pixel_fetch dut (
    .clk        (clk),
    .reset      (reset),
`ifdef VGA_FETCH_TESTPAT_EN
    .test_en    (test_en),
`endif
    .in_x       (in_x),
    .in_y       (in_y),
    .in_video_on(in_video_on),
    .in_hsync   (in_hsync),
    .in_vsync   (in_vsync),
    .in_blank   (in_blank),
    .in_sync    (in_sync),
    .pix_addr   (pix_addr),
    .pix_rd_en  (pix_rd_en),
    .pix_data   (pix_data),
    .hsync      (hsync),
    .vsync      (vsync),
    .blank      (blank),
    .sync       (sync),
    .rgb_r      (rgb_r),
    .rgb_g      (rgb_g),
    .rgb_b      (rgb_b),
    .frame_start(frame_start)
  );

  typedef struct packed {
    logic [3:0] strb;
    logic [7:0] g;
    logic       fs;
  } exp_t;

  localparam exp_t RST_E = '{strb: 4'b1100, g: 8'h00, fs: 1'b0};

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] m_addr = 16'h0000;
  logic        m_rd   = 1'b0;

  // framebuffer: two-cycle read pipeline of a fixed content function
  function automatic logic [7:0] fb_val(input logic [15:0] a);
    if (a == 16'h0000) return 8'hA5;
    return a[7:0] ^ {a[14:8], 1'b0} ^ 8'h3C;
  endfunction

  logic [7:0] fb1 = 8'h00;
  logic [7:0] fb2 = 8'h00;
  always @(posedge clk) begin
    fb1 <= fb_val(pix_addr);
    fb2 <= fb1;
  end
  assign pix_data = fb2;

  task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic rst, input logic [9:0] x, input logic [9:0] y,
                      input logic von, input logic [3:0] strb, input logic tst);
    exp_t       e;
    exp_t       got;
    logic       win;
    logic [9:0] xr, yr;
    reset       = rst;
    in_x        = x;
    in_y        = y;
    in_video_on = von;
    {in_hsync, in_vsync, in_blank, in_sync} = strb;
`ifdef VGA_FETCH_TESTPAT_EN
    test_en     = tst;
`endif
    xr  = x - 10'd192;
    yr  = y - 10'd112;
    win = von && (x >= 10'd192) && (x <= 10'd447) && (y >= 10'd112) && (y <= 10'd367);
    e.strb = strb;
    e.fs   = von && (x == 10'd0) && (y == 10'd0);
    if (win)      e.g = tst ? (xr[7:0] ^ yr[7:0]) : fb_val({yr[7:0], xr[7:0]});
    else if (von) e.g = 8'h20;
    else          e.g = 8'h00;
    if (rst) begin
      foreach (sb[i]) sb[i] = RST_E;
      e      = RST_E;
      m_addr = 16'h0000;
      m_rd   = 1'b0;
    end else begin
      m_rd = win && !tst;
      if (win) m_addr = {yr[7:0], xr[7:0]};
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    check("pix_rd_en", 24'(pix_rd_en), 24'(m_rd));
    check("pix_addr", 24'(pix_addr), 24'(m_addr));
    if (sb.size() > L) begin
      got = sb.pop_front();
      check("strobes", 24'({hsync, vsync, blank, sync}), 24'(got.strb));
      check("rgb", {rgb_r, rgb_g, rgb_b}, {got.g, got.g, got.g});
      check("frame_start", 24'(frame_start), 24'(got.fs));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (L) sb.push_back(RST_E);

    repeat (5) step(1'b1, 10'd0, 10'd0, 1'b0, 4'b1100, 1'b0);
    // release with video off: strobes still reset for L cycles
    step(1'b0, 10'd0, 10'd0, 1'b0, 4'b0110, 1'b0);
    step(1'b0, 10'd1, 10'd0, 1'b0, 4'b1001, 1'b0);
    step(1'b0, 10'd2, 10'd0, 1'b0, 4'b0111, 1'b0);
    step(1'b0, 10'd0, 10'd0, 1'b1, 4'b1110, 1'b0);
    step(1'b0, 10'd1, 10'd0, 1'b1, 4'b1110, 1'b0);

    // left window edge on first image line
    for (int x = 190; x <= 194; x++) step(1'b0, 10'(x), 10'd112, 1'b1, 4'b1110, 1'b0);
    // bottom-right corner and column past it
    step(1'b0, 10'd447, 10'd367, 1'b1, 4'b1110, 1'b0);
    step(1'b0, 10'd448, 10'd367, 1'b1, 4'b1110, 1'b0);
    step(1'b0, 10'd447, 10'd368, 1'b1, 4'b1110, 1'b0);

    // hsync pulse in the middle of image pixels
    step(1'b0, 10'd300, 10'd200, 1'b1, 4'b0110, 1'b0);
    step(1'b0, 10'd301, 10'd200, 1'b1, 4'b1110, 1'b0);
    step(1'b0, 10'd302, 10'd200, 1'b1, 4'b0110, 1'b0);

    // inside window but video off
    step(1'b0, 10'd250, 10'd150, 1'b0, 4'b1100, 1'b0);
    step(1'b0, 10'd251, 10'd150, 1'b0, 4'b1100, 1'b0);

    for (int i = 0; i < 8; i++)
      step(1'b0, 10'(192 + $urandom_range(0, 255)), 10'(112 + $urandom_range(0, 255)),
           1'b1, 4'b1110, 1'b0);

    // mid-frame reset pulse
    step(1'b0, 10'd299, 10'd200, 1'b1, 4'b1110, 1'b0);
    step(1'b1, 10'd300, 10'd200, 1'b1, 4'b1110, 1'b0);
    for (int x = 301; x <= 306; x++) step(1'b0, 10'(x), 10'd200, 1'b1, 4'b1110, 1'b0);

`ifdef VGA_FETCH_TESTPAT_EN
    step(1'b0, 10'd195, 10'd117, 1'b1, 4'b1110, 1'b1);
    step(1'b0, 10'd196, 10'd117, 1'b1, 4'b1110, 1'b1);
    step(1'b0, 10'd190, 10'd117, 1'b1, 4'b1110, 1'b1);
    step(1'b0, 10'd195, 10'd117, 1'b1, 4'b1110, 1'b0);
`endif

    repeat (L + 1) step(1'b0, 10'd700, 10'd500, 1'b0, 4'b1100, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
